// File: rtl/ntt_polyvec_sched.sv
// Round-robin scheduler that shares one NTT_wrapper among N_REQ polyvec requesters.
// Optional watchdog abort of a stalled NTT is compiled in with NTT_SCHED_WDT_EN.
//
// state   | meaning
// S_IDLE  | no job; arbitrate pending requests
// S_ISSUE | run pulse to NTT for poly idx (suppressed for an empty job)
// S_WAIT  | waiting for the NTT done pulse
// S_WB    | result writeback strobe for poly idx
// S_DONE  | completion pulse to the granted requester
module ntt_polyvec_sched #(
  parameter int N_REQ      = 3,
  parameter int K          = 3,
  parameter int IDX_W      = $clog2(K),
  parameter int WDT_CYCLES = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [2*N_REQ-1:0]         req_mode_i,
  input  logic [(IDX_W+1)*N_REQ-1:0] req_len_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       busy_o,
  output logic                       ntt_run_o,
  output logic [1:0]                 ntt_mode_o,
  output logic [IDX_W-1:0]           ntt_idx_o,
  input  logic                       ntt_done_i,
  output logic                       res_we_o,
  output logic [IDX_W-1:0]           res_idx_o,
  output logic [N_REQ-1:0]           job_done_o,
  output logic                       err_o
);

  localparam int LEN_W = IDX_W + 1;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   N_REQ_P  = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);
  localparam logic [LEN_W-1:0] K_LEN    = LEN_W'(K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  gnt_idx_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic              run_q;
  logic              we_q;
  logic [N_REQ-1:0]  jd_q;

  logic [N_REQ-1:0]  req_rot;
  logic              pick_vld;
  logic [PTR_W-1:0]  pick_off;
  logic [PTR_W:0]    win_sum;
  logic [PTR_W-1:0]  win_idx;
  logic [1:0]        win_mode;
  logic [LEN_W-1:0]  win_len_raw;
  logic [LEN_W-1:0]  win_len;
  logic              last_poly;
  logic [PTR_W-1:0]  ptr_next;

  // Rotate requests so bit 0 is the requester at the rr pointer; lowest set bit wins.
  assign req_rot = N_REQ'({req_i, req_i} >> ptr_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_vld = 1'b1;
        pick_off = PTR_W'(i);
      end
    end
  end

  assign win_sum = {1'b0, ptr_q} + {1'b0, pick_off};
  assign win_idx = (win_sum >= N_REQ_P) ? PTR_W'(win_sum - N_REQ_P) : PTR_W'(win_sum);

  always_comb begin
    win_mode    = '0;
    win_len_raw = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_mode    = req_mode_i[2*i +: 2];
        win_len_raw = req_len_i[LEN_W*i +: LEN_W];
      end
    end
  end

  assign win_len   = (win_len_raw > K_LEN) ? K_LEN : win_len_raw;
  assign last_poly = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign ptr_next  = (gnt_idx_q == LAST_REQ) ? '0 : gnt_idx_q + PTR_W'(1);

`ifdef NTT_SCHED_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q;
  logic             err_q;

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      run_q     <= 1'b0;
      we_q      <= 1'b0;
      jd_q      <= '0;
`ifdef NTT_SCHED_WDT_EN
      wdt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      run_q <= 1'b0;
      we_q  <= 1'b0;
      jd_q  <= '0;
`ifdef NTT_SCHED_WDT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_q     <= N_REQ'(1) << win_idx;
            gnt_idx_q <= win_idx;
            mode_q    <= win_mode;
            len_q     <= win_len;
            idx_q     <= '0;
            run_q     <= (win_len != '0);
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // An empty job passes through ISSUE without a run pulse.
          if (len_q == '0) begin
            jd_q    <= gnt_q;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
`ifdef NTT_SCHED_WDT_EN
            wdt_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (ntt_done_i) begin
            we_q    <= 1'b1;
            state_q <= S_WB;
`ifdef NTT_SCHED_WDT_EN
          end else if (wdt_q == WDT_LAST) begin
            jd_q    <= gnt_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdt_q   <= wdt_q + WDT_W'(1);
`endif
          end
        end
        S_WB: begin
          if (last_poly) begin
            jd_q    <= gnt_q;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            run_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          gnt_q   <= '0;
          ptr_q   <= ptr_next;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q != S_IDLE);
  assign ntt_run_o  = run_q;
  assign ntt_mode_o = mode_q;
  assign ntt_idx_o  = idx_q;
  assign res_we_o   = we_q;
  assign res_idx_o  = idx_q;
  assign job_done_o = jd_q;

endmodule
